// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, flush bubbles
// and saturating stall/flush event counters.
module id_ex_stage #(
    parameter int DW = 32,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          id_regDst,
    input  logic          id_branch,
    input  logic          id_memRead,
    input  logic          id_memToReg,
    input  logic          id_regWrite,
    input  logic          id_ALUSrc,
    input  logic          id_memWrite,
    input  logic [2:0]    id_ALUop,
    input  logic [DW-1:0] id_pc4,
    input  logic [DW-1:0] id_rs_data,
    input  logic [DW-1:0] id_rt_data,
    input  logic [DW-1:0] id_imm,
    input  logic [4:0]    id_rs_addr,
    input  logic [4:0]    id_rt_addr,
    input  logic [4:0]    id_rd_addr,
    input  logic          flush,
    output logic          ex_regDst,
    output logic          ex_branch,
    output logic          ex_memRead,
    output logic          ex_memToReg,
    output logic          ex_regWrite,
    output logic          ex_ALUSrc,
    output logic          ex_memWrite,
    output logic [2:0]    ex_ALUop,
    output logic [DW-1:0] ex_pc4,
    output logic [DW-1:0] ex_rs_data,
    output logic [DW-1:0] ex_rt_data,
    output logic [DW-1:0] ex_imm,
    output logic [4:0]    ex_rs_addr,
    output logic [4:0]    ex_rt_addr,
    output logic [4:0]    ex_rd_addr,
    output logic          pc_write,
    output logic          ifid_write,
    output logic [CW-1:0] stall_cnt,
    output logic [CW-1:0] flush_cnt
);

    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic       hazard;
    logic       rt_match;
    logic       bubble;
    logic       c_regDst;
    logic       c_branch;
    logic       c_memRead;
    logic       c_memToReg;
    logic       c_regWrite;
    logic       c_ALUSrc;
    logic       c_memWrite;
    logic [2:0] c_ALUop;

    always_comb begin
        rt_match = (ex_rt_addr == id_rs_addr) || (ex_rt_addr == id_rt_addr);
        hazard   = ex_memRead && (ex_rt_addr != 5'd0) && rt_match;
        bubble   = flush || hazard;
    end

    assign pc_write   = ~hazard | flush;
    assign ifid_write = ~hazard | flush;

    // if-statements resolve an unknown condition to the else path, so
    // X control bits from the decoder are loaded as 0.
    always_comb begin
        c_regDst   = 1'b0;
        c_branch   = 1'b0;
        c_memRead  = 1'b0;
        c_memToReg = 1'b0;
        c_regWrite = 1'b0;
        c_ALUSrc   = 1'b0;
        c_memWrite = 1'b0;
        c_ALUop    = '0;
        if (id_regWrite && id_regDst) c_regDst   = 1'b1;
        if (id_branch)                c_branch   = 1'b1;
        if (id_memRead)               c_memRead  = 1'b1;
        if (id_memToReg)              c_memToReg = 1'b1;
        if (id_regWrite)              c_regWrite = 1'b1;
        if (id_ALUSrc)                c_ALUSrc   = 1'b1;
        if (id_memWrite)              c_memWrite = 1'b1;
        for (int unsigned i = 0; i < 3; i++) begin
            if (id_ALUop[i]) c_ALUop[i] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_regDst   <= 1'b0;
            ex_branch   <= 1'b0;
            ex_memRead  <= 1'b0;
            ex_memToReg <= 1'b0;
            ex_regWrite <= 1'b0;
            ex_ALUSrc   <= 1'b0;
            ex_memWrite <= 1'b0;
            ex_ALUop    <= '0;
        end else if (bubble) begin
            ex_regDst   <= 1'b0;
            ex_branch   <= 1'b0;
            ex_memRead  <= 1'b0;
            ex_memToReg <= 1'b0;
            ex_regWrite <= 1'b0;
            ex_ALUSrc   <= 1'b0;
            ex_memWrite <= 1'b0;
            ex_ALUop    <= '0;
        end else begin
            ex_regDst   <= c_regDst;
            ex_branch   <= c_branch;
            ex_memRead  <= c_memRead;
            ex_memToReg <= c_memToReg;
            ex_regWrite <= c_regWrite;
            ex_ALUSrc   <= c_ALUSrc;
            ex_memWrite <= c_memWrite;
            ex_ALUop    <= c_ALUop;
        end
    end

    // Data and addresses are captured unconditionally; a bubble is defined
    // purely by its control bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_pc4     <= '0;
            ex_rs_data <= '0;
            ex_rt_data <= '0;
            ex_imm     <= '0;
            ex_rs_addr <= '0;
            ex_rt_addr <= '0;
            ex_rd_addr <= '0;
        end else begin
            ex_pc4     <= id_pc4;
            ex_rs_data <= id_rs_data;
            ex_rt_data <= id_rt_data;
            ex_imm     <= id_imm;
            ex_rs_addr <= id_rs_addr;
            ex_rt_addr <= id_rt_addr;
            ex_rd_addr <= id_rd_addr;
        end
    end

    // A flush takes priority over a coincident hazard for accounting too.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (flush) begin
            if (flush_cnt != '1) flush_cnt <= flush_cnt + CNT_ONE;
        end else if (hazard) begin
            if (stall_cnt != '1) stall_cnt <= stall_cnt + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus random traffic
// compared against an instruction-level model of the EX register.
module tb_id_ex_stage;

    localparam int DW  = 32;
    localparam int CW  = 2;
    localparam int SAT = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          id_regDst, id_branch, id_memRead, id_memToReg;
    logic          id_regWrite, id_ALUSrc, id_memWrite;
    logic [2:0]    id_ALUop;
    logic [DW-1:0] id_pc4, id_rs_data, id_rt_data, id_imm;
    logic [4:0]    id_rs_addr, id_rt_addr, id_rd_addr;
    logic          flush;
    logic          ex_regDst, ex_branch, ex_memRead, ex_memToReg;
    logic          ex_regWrite, ex_ALUSrc, ex_memWrite;
    logic [2:0]    ex_ALUop;
    logic [DW-1:0] ex_pc4, ex_rs_data, ex_rt_data, ex_imm;
    logic [4:0]    ex_rs_addr, ex_rt_addr, ex_rd_addr;
    logic          pc_write, ifid_write;
    logic [CW-1:0] stall_cnt, flush_cnt;

    id_ex_stage #(.DW(DW), .CW(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_regDst(id_regDst), .id_branch(id_branch), .id_memRead(id_memRead),
        .id_memToReg(id_memToReg), .id_regWrite(id_regWrite), .id_ALUSrc(id_ALUSrc),
        .id_memWrite(id_memWrite), .id_ALUop(id_ALUop),
        .id_pc4(id_pc4), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr), .id_rd_addr(id_rd_addr),
        .flush(flush),
        .ex_regDst(ex_regDst), .ex_branch(ex_branch), .ex_memRead(ex_memRead),
        .ex_memToReg(ex_memToReg), .ex_regWrite(ex_regWrite), .ex_ALUSrc(ex_ALUSrc),
        .ex_memWrite(ex_memWrite), .ex_ALUop(ex_ALUop),
        .ex_pc4(ex_pc4), .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm),
        .ex_rs_addr(ex_rs_addr), .ex_rt_addr(ex_rt_addr), .ex_rd_addr(ex_rd_addr),
        .pc_write(pc_write), .ifid_write(ifid_write),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Model of the instruction sitting in EX.
    // ctl layout: {regDst,branch,memRead,memToReg,regWrite,ALUSrc,memWrite,ALUop[2:0]}
    logic [9:0]   m_ctl;
    logic [127:0] m_data;
    logic [14:0]  m_addr;
    bit           m_data_valid;
    int           m_stall, m_flush;

    localparam logic [9:0] ADD = {1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'b010};
    localparam logic [9:0] LW  = {1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 3'b000};
    localparam logic [9:0] BEQ = {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b001};
    localparam logic [9:0] SWX = {1'bx, 1'b0, 1'b0, 1'bx, 1'b0, 1'bx, 1'b1, 3'b000};

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [9:0] out_ctl();
        return {ex_regDst, ex_branch, ex_memRead, ex_memToReg, ex_regWrite,
                ex_ALUSrc, ex_memWrite, ex_ALUop};
    endfunction

    task automatic model_reset();
        m_ctl = '0; m_data = '0; m_addr = '0; m_data_valid = 1'b1;
        m_stall = 0; m_flush = 0;
    endtask

    task automatic check_outputs(input string tag);
        logic any_x;
        check({tag, ".ctl"}, 128'(out_ctl()), 128'(m_ctl));
        if (m_data_valid) begin
            check({tag, ".data"}, {ex_pc4, ex_rs_data, ex_rt_data, ex_imm}, m_data);
            check({tag, ".addr"}, 128'({ex_rs_addr, ex_rt_addr, ex_rd_addr}), 128'(m_addr));
        end
        check({tag, ".stall_cnt"}, 128'(stall_cnt), 128'(m_stall));
        check({tag, ".flush_cnt"}, 128'(flush_cnt), 128'(m_flush));
        any_x = $isunknown({out_ctl(), ex_pc4, ex_rs_data, ex_rt_data, ex_imm,
                            ex_rs_addr, ex_rt_addr, ex_rd_addr, stall_cnt, flush_cnt});
        check({tag, ".no_x"}, 128'(any_x), 128'(0));
    endtask

    // One ID-stage instruction presented for one cycle, then EX checked.
    task automatic step(input string tag, input logic [9:0] ctl,
                        input logic [DW-1:0] pc4, input logic [DW-1:0] rs, input logic [DW-1:0] rt,
                        input logic [DW-1:0] imm, input logic [4:0] rsa, input logic [4:0] rta,
                        input logic [4:0] rda, input logic fl);
        bit         haz;
        logic [9:0] clean;
        {id_regDst, id_branch, id_memRead, id_memToReg, id_regWrite,
         id_ALUSrc, id_memWrite, id_ALUop} = ctl;
        id_pc4 = pc4; id_rs_data = rs; id_rt_data = rt; id_imm = imm;
        id_rs_addr = rsa; id_rt_addr = rta; id_rd_addr = rda; flush = fl;
        #1;
        haz = (m_ctl[7] === 1'b1) && (m_addr[9:5] != 0) &&
              (m_addr[9:5] == rsa || m_addr[9:5] == rta);
        check({tag, ".pc_write"},   128'(pc_write),   128'(!haz || fl));
        check({tag, ".ifid_write"}, 128'(ifid_write), 128'(!haz || fl));
        for (int i = 0; i < 10; i++) clean[i] = (ctl[i] === 1'b1);
        clean[9] = (ctl[9] === 1'b1) && (ctl[5] === 1'b1);
        if (fl) begin
            m_ctl = '0; m_data_valid = 1'b1;
            if (m_flush < SAT) m_flush++;
        end else if (haz) begin
            m_ctl = '0; m_data_valid = 1'b0;
            if (m_stall < SAT) m_stall++;
        end else begin
            m_ctl = clean; m_data_valid = 1'b1;
        end
        m_data = {pc4, rs, rt, imm};
        m_addr = {rsa, rta, rda};
        @(posedge clk);
        @(negedge clk);
        check_outputs(tag);
    endtask

    initial begin
        rst_n = 1'b0;
        {id_regDst, id_branch, id_memRead, id_memToReg, id_regWrite,
         id_ALUSrc, id_memWrite, id_ALUop} = '0;
        id_pc4 = '0; id_rs_data = '0; id_rt_data = '0; id_imm = '0;
        id_rs_addr = '0; id_rt_addr = '0; id_rd_addr = '0; flush = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_outputs("reset");
        check("reset.pc_write", 128'(pc_write), 128'(1));
        rst_n = 1'b1;

        // ADD passes straight through
        step("add", ADD, 32'h104, 32'd5, 32'd7, 32'd0, 5'd1, 5'd2, 5'd3, 1'b0);
        check("add.rs_data", 128'(ex_rs_data), 128'(5));
        check("add.ALUop", 128'(ex_ALUop), 128'(3'b010));

        // Load-use: one stall, then the held consumer advances
        step("lw8",      LW,  32'h108, 32'd0, 32'd0, 32'd4, 5'd1, 5'd8, 5'd0, 1'b0);
        step("use8_st",  ADD, 32'h10c, 32'd9, 32'd3, 32'd0, 5'd8, 5'd2, 5'd4, 1'b0);
        check("use8.stall_cnt", 128'(stall_cnt), 128'(1));
        step("use8_go",  ADD, 32'h10c, 32'd9, 32'd3, 32'd0, 5'd8, 5'd2, 5'd4, 1'b0);

        // Load to $0 never stalls
        step("lw0",      LW,  32'h110, 32'd0, 32'd0, 32'd8, 5'd1, 5'd0, 5'd0, 1'b0);
        step("use0",     ADD, 32'h114, 32'd1, 32'd2, 32'd0, 5'd0, 5'd0, 5'd5, 1'b0);

        // Flush alone, then flush coinciding with a load-use hazard
        step("flush",    BEQ, 32'h118, 32'd1, 32'd1, 32'd2, 5'd3, 5'd3, 5'd0, 1'b1);
        step("lw9",      LW,  32'h11c, 32'd0, 32'd0, 32'd0, 5'd1, 5'd9, 5'd0, 1'b0);
        step("flushhaz", ADD, 32'h120, 32'd1, 32'd1, 32'd0, 5'd9, 5'd9, 5'd6, 1'b1);
        check("flushhaz.stall_cnt", 128'(stall_cnt), 128'(1));

        // Unknown decoder bits are sanitised
        step("sw_x",     SWX, 32'h124, 32'd11, 32'd12, 32'd16, 5'd2, 5'd7, 5'd0, 1'b0);
        check("sw_x.regDst", 128'(ex_regDst), 128'(0));
        check("sw_x.memWrite", 128'(ex_memWrite), 128'(1));

        // Five load-use stalls saturate the 2-bit counter
        for (int k = 0; k < 5; k++) begin
            step("sat_lw",  LW,  32'h200, 32'd0, 32'd0, 32'd0, 5'd1, 5'd10, 5'd0, 1'b0);
            step("sat_st",  ADD, 32'h204, 32'd1, 32'd2, 32'd0, 5'd10, 5'd1, 5'd2, 1'b0);
            step("sat_go",  ADD, 32'h204, 32'd1, 32'd2, 32'd0, 5'd10, 5'd1, 5'd2, 1'b0);
        end
        check("sat.stall_cnt", 128'(stall_cnt), 128'(SAT));
        for (int k = 0; k < 4; k++)
            step("sat_fl", BEQ, 32'h208, 32'd0, 32'd0, 32'd0, 5'd1, 5'd1, 5'd0, 1'b1);
        check("sat.flush_cnt", 128'(flush_cnt), 128'(SAT));

        // Reset asserted in the middle of a stall clears everything at once
        step("rst_lw", LW, 32'h300, 32'd0, 32'd0, 32'd0, 5'd1, 5'd12, 5'd0, 1'b0);
        {id_regDst, id_branch, id_memRead, id_memToReg, id_regWrite,
         id_ALUSrc, id_memWrite, id_ALUop} = ADD;
        id_rs_addr = 5'd12; flush = 1'b0;
        #1;
        check("rst_mid.pc_write_pre", 128'(pc_write), 128'(0));
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs("rst_mid");
        check("rst_mid.pc_write", 128'(pc_write), 128'(1));
        check("rst_mid.ifid_write", 128'(ifid_write), 128'(1));
        @(negedge clk);
        rst_n = 1'b1;

        // Random traffic with small register indices to provoke hazards
        for (int n = 0; n < 300; n++) begin
            logic [9:0] c;
            c = 10'($urandom);
            c[7] = ($urandom_range(0, 1) == 1);
            step("rand", c, $urandom, $urandom, $urandom, $urandom,
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 5'($urandom_range(0, 31)), ($urandom_range(0, 7) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Pipeline register between the ID stage (instruction decoder/control unit, register file, sign-extender) and the EX stage (ALU, ALU control, forwarding muxes).
- Latches the decoder control bundle, operands and register addresses every cycle.
- Contains the load-use hazard detector that stalls PC and IF/ID, and inserts a bubble into EX.
- Applies branch/jump flushes and keeps saturating stall/bubble performance counters.

Parameters:
- DW, 32, datapath width (operands, PC+4, immediate)
- CW, 16, width of stall_cnt and flush_cnt

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  reset, asynchronous, active-low; one clock domain only
- id_regDst, id_branch, id_memRead, id_memToReg, id_regWrite, id_ALUSrc, id_memWrite  input  1 each  decoder control bits; may be X when unused
- id_ALUop  input  3  decoder ALU operation code
- id_pc4  input  DW  PC+4 of the ID instruction
- id_rs_data, id_rt_data  input  DW  register file read data
- id_imm  input  DW  sign-extended immediate
- id_rs_addr, id_rt_addr, id_rd_addr  input  5  instruction register fields
- flush  input  1  branch/jump redirect resolved; kill the ID instruction
- ex_regDst, ex_branch, ex_memRead, ex_memToReg, ex_regWrite, ex_ALUSrc, ex_memWrite  output  1 each  registered control bits
- ex_ALUop  output  3  registered ALU operation code
- ex_pc4, ex_rs_data, ex_rt_data, ex_imm  output  DW  registered data
- ex_rs_addr, ex_rt_addr, ex_rd_addr  output  5  registered addresses
- pc_write  output  1  PC update enable (combinational)
- ifid_write  output  1  IF/ID register enable (combinational)
- stall_cnt  output  CW  count of load-use stall cycles
- flush_cnt  output  CW  count of flush bubbles

Behaviour:
- Reset (rst_n=0, asynchronous):
  - All ex_* outputs become 0, which equals a NOP bubble.
  - Both counters become 0.
- hazard (combinational) = ex_memRead & (ex_rt_addr!=0) & (ex_rt_addr==id_rs_addr | ex_rt_addr==id_rt_addr).
  - The comparison is conservative: rt is compared even for instructions that do not read it.
- pc_write = ifid_write = ~hazard | flush.
  - A flush always lets the redirect proceed.
- On each rising edge, the first matching case applies:
  1. flush=1:
     - Load a bubble: all ex control bits 0, ex_ALUop=0.
     - Data and address fields still capture the id_* values (don't-care).
     - flush_cnt increments.
  2. hazard=1:
     - Load a bubble.
     - stall_cnt increments.
     - IF/ID and PC hold via the enables.
  3. Otherwise, capture every id_* input into the matching ex_* output.
- X sanitising: when id_regWrite=0, ex_regDst is loaded as 0. When id_ALUSrc is X, it is loaded as 0. No X reaches any ex_* output after reset.
- Latency: exactly 1 cycle from ID to EX. There is no internal buffering.
- A load-use stall lasts exactly 1 cycle. The next cycle, ex_memRead=0 (bubble), so hazard deasserts and the held instruction advances.
- Back-to-back loads where each next instruction depends on the previous one: each pair costs 1 stall.
- Counters saturate at 2^CW-1 and never wrap.
- Flush and hazard together: bubble, flush_cnt+1, stall_cnt unchanged, pc_write=ifid_write=1.
- Reset asserted mid-stall: outputs clear immediately. hazard drops because ex_memRead=0.

Test Plan:
1. Reset then release; drive ADD (regDst=1, ALUop=010, regWrite=1, ALUSrc=0), rs_data=5, rt_data=7 -> next edge ex_regWrite=1, ex_ALUop=010, ex_rs_data=5, ex_rt_data=7; pc_write=1.
2. LW $8 (memRead=1, rt=8) followed by ADD with rs=8 -> one cycle with pc_write=0, ifid_write=0, EX bubble (all control 0), stall_cnt=1; the next cycle ADD enters EX.
3. LW $0 followed by a consumer with rs=0 -> no stall, stall_cnt stays 0.
4. flush=1 with BEQ held in ID, and flush together with a load-use hazard -> EX bubble, flush_cnt increments each time, stall_cnt unchanged, pc_write=1.
5. SW with id_regDst=X, id_regWrite=0 -> ex_regDst=0, ex_memWrite=1, no X on any output.
6. Preload behaviour with CW=2 and 5 stall events -> stall_cnt saturates at 3; assert rst_n=0 mid-stall -> all outputs 0 asynchronously before the next edge.
